// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div sequencer
// state encoding, default latencies and the register-zero constant.
package hazard_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_LAT = 4;
  localparam int DEF_DIV_LAT  = 32;
  localparam int DEF_CNT_W    = 6;
  localparam int DEF_PERF_W   = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an ID source operand is actually read and names the given register.
  function automatic logic src_hits(input logic [4:0] src, input logic used,
                                    input logic [4:0] waddr);
    return used && (src == waddr);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div occupancy sequencer: tracks how long the HI/LO unit stays busy,
// pulses done on the edge results land, and flags overlapping starts.
module hazard_ctrl_md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_mult_i,
  input  logic kill_i,
  output logic busy_o,
  output logic done_o,
  output logic overlap_err_o
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             overlap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          // A start alongside a redirect belongs to the wrong path.
          if (start_i && !kill_i) begin
            state_q <= MD_RUN;
            cnt_q   <= is_mult_i ? MULT_LOAD : DIV_LOAD;
          end
        end
        MD_RUN: begin
          if (start_i) begin
            overlap_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= MD_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q == MD_RUN);
  assign done_o        = done_q;
  assign overlap_err_o = overlap_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO dependency stalls, MEM-stage
// redirect flushes, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PERF_W   = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_lhr,
  input  logic              ex_mem_read,
  input  logic              ex_rf_wen,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_md_start,
  input  logic              ex_md_is_mult,
  input  logic              mem_redirect,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_clr,
  output logic              id_ex_clr,
  output logic              ex_mem_clr,
  output logic              md_busy,
  output logic              md_done,
  output logic              md_overlap_err,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              lu;
  logic              mdh;
  logic              stall;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  hazard_ctrl_md_seq #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (ex_md_start),
    .is_mult_i    (ex_md_is_mult),
    .kill_i       (mem_redirect),
    .busy_o       (md_busy),
    .done_o       (md_done),
    .overlap_err_o(md_overlap_err)
  );

  assign lu = ex_mem_read && ex_rf_wen && (ex_waddr != REG_ZERO) &&
              (src_hits(id_rs, id_uses_rs, ex_waddr) ||
               src_hits(id_rt, id_uses_rt, ex_waddr));

  // A start being accepted this cycle already blocks HI/LO users in ID.
  assign mdh   = id_uses_lhr && (md_busy || (!md_busy && ex_md_start));
  assign stall = lu || mdh;

  always_comb begin
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    ex_mem_clr = 1'b0;
    if (mem_redirect) begin
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      ex_mem_clr = 1'b1;
    end else if (stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_clr = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !mem_redirect && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-indexed behavioural model of the controller.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 6;
  localparam int PERF_W   = 6;
  localparam int CNT_MAX  = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_waddr;
  logic id_uses_rs, id_uses_rt, id_uses_lhr;
  logic ex_mem_read, ex_rf_wen, ex_md_start, ex_md_is_mult, mem_redirect;
  logic pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr;
  logic md_busy, md_done, md_overlap_err;
  logic [PERF_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W),
    .PERF_W  (PERF_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_uses_lhr   (id_uses_lhr),
    .ex_mem_read   (ex_mem_read),
    .ex_rf_wen     (ex_rf_wen),
    .ex_waddr      (ex_waddr),
    .ex_md_start   (ex_md_start),
    .ex_md_is_mult (ex_md_is_mult),
    .mem_redirect  (mem_redirect),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_clr     (if_id_clr),
    .id_ex_clr     (id_ex_clr),
    .ex_mem_clr    (ex_mem_clr),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .md_overlap_err(md_overlap_err),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic [4:0] rs, rt, wa;
    bit urs, urt, ulhr, mrd, wen, st, mul, redir;
  } stim_t;

  typedef struct {
    int cyc;
    bit pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr;
    bit busy, done, ovl;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycle c is the interval after the c-th rising edge. An operation
  // accepted in cycle T occupies T+1..T+LAT and completes in cycle T+LAT+1.
  int cyc = 0;
  bit md_valid;
  int md_t, md_lat;
  bit m_ovl;
  int m_cnt;

  function automatic void chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endfunction

  function automatic void model_reset();
    md_valid = 1'b0;
    md_t     = -1000;
    md_lat   = 0;
    m_ovl    = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rs: 5'd0, rt: 5'd0, wa: 5'd0, urs: 0, urt: 0, ulhr: 0, mrd: 0,
          wen: 0, st: 0, mul: 0, redir: 0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit busy, lu, stall;
    @(posedge clk);
    cyc++;
    #1;
    id_rs = s.rs; id_rt = s.rt; ex_waddr = s.wa;
    id_uses_rs = s.urs; id_uses_rt = s.urt; id_uses_lhr = s.ulhr;
    ex_mem_read = s.mrd; ex_rf_wen = s.wen;
    ex_md_start = s.st; ex_md_is_mult = s.mul; mem_redirect = s.redir;

    busy  = md_valid && (cyc > md_t) && (cyc <= md_t + md_lat);
    lu    = s.mrd && s.wen && (s.wa != 0) &&
            ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
    stall = lu || (s.ulhr && (busy || s.st));

    e.cyc  = cyc;
    e.busy = busy;
    e.done = md_valid && (cyc == md_t + md_lat + 1);
    e.ovl  = m_ovl;
    e.cnt  = m_cnt;
    e.pc_en      = s.redir || !stall;
    e.if_id_en   = s.redir || !stall;
    e.if_id_clr  = s.redir;
    e.id_ex_clr  = s.redir || stall;
    e.ex_mem_clr = s.redir;
    exp_q.push_back(e);

    if (s.st && busy) m_ovl = 1'b1;
    if (s.st && !busy && !s.redir) begin
      md_valid = 1'b1;
      md_t     = cyc;
      md_lat   = s.mul ? MULT_LAT : DIV_LAT;
    end
    if (stall && !s.redir && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(idle_stim());
  endtask

  // Reset asserted mid-cycle; outputs must respond before the next edge.
  task automatic async_reset_check();
    @(posedge clk);
    cyc++;
    #1;
    id_uses_rs = 0; id_uses_rt = 0; id_uses_lhr = 0;
    ex_md_start = 0; mem_redirect = 0; ex_mem_read = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ovl", md_overlap_err, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_id_ex_clr", id_ex_clr, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_en", pc_en, e.pc_en);
      chk("if_id_en", if_id_en, e.if_id_en);
      chk("if_id_clr", if_id_clr, e.if_id_clr);
      chk("id_ex_clr", id_ex_clr, e.id_ex_clr);
      chk("ex_mem_clr", ex_mem_clr, e.ex_mem_clr);
      chk("md_busy", md_busy, e.busy);
      chk("md_done", md_done, e.done);
      chk("md_overlap_err", md_overlap_err, e.ovl);
      chk("stall_cnt", stall_cnt, e.cnt);
      $display("txn cyc=%0d pc_en=%0b if_id_en=%0b clr=%0b%0b%0b busy=%0b done=%0b ovl=%0b cnt=%0d",
               e.cyc, pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr,
               md_busy, md_done, md_overlap_err, stall_cnt);
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    id_rs = 0; id_rt = 0; ex_waddr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_uses_lhr = 0;
    ex_mem_read = 0; ex_rf_wen = 0; ex_md_start = 0; ex_md_is_mult = 0;
    mem_redirect = 0;
    model_reset();
    #12;
    chk("init_pc_en", pc_en, 1);
    chk("init_busy", md_busy, 0);
    chk("init_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    idle(2);
    // Load-use on rs, then the same with destination r0.
    s = idle_stim(); s.mrd = 1; s.wen = 1; s.wa = 5'd8; s.rs = 5'd8; s.urs = 1;
    drive(s);
    idle(1);
    s.wa = 5'd0; s.rs = 5'd0;
    drive(s);
    idle(1);
    // Load-use on rt.
    s = idle_stim(); s.mrd = 1; s.wen = 1; s.wa = 5'd5; s.rt = 5'd5; s.urt = 1;
    drive(s);
    // Mult followed by a HI/LO reader held in ID.
    s = idle_stim(); s.st = 1; s.mul = 1; s.ulhr = 1;
    drive(s);
    s = idle_stim(); s.ulhr = 1;
    for (int i = 0; i < 6; i++) drive(s);
    idle(2);
    // Div with no HI/LO users.
    s = idle_stim(); s.st = 1;
    drive(s);
    idle(DIV_LAT + 2);
    // Redirect together with load-use, and a start killed by redirect.
    s = idle_stim(); s.mrd = 1; s.wen = 1; s.wa = 5'd3; s.rs = 5'd3; s.urs = 1; s.redir = 1;
    drive(s);
    s = idle_stim(); s.st = 1; s.mul = 1; s.redir = 1;
    drive(s);
    idle(2);
    // Overlapping start while a mult runs.
    s = idle_stim(); s.st = 1; s.mul = 1;
    drive(s);
    idle(1);
    s.mul = 0;
    drive(s);
    idle(MULT_LAT + 2);
    // Back-to-back: new start in the cycle md_done is high.
    s = idle_stim(); s.st = 1; s.mul = 1;
    drive(s);
    idle(MULT_LAT);
    drive(s);
    idle(MULT_LAT + 2);
    // Reset in the middle of a div.
    s = idle_stim(); s.st = 1;
    drive(s);
    idle(DIV_LAT - 11);
    async_reset_check();
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.wa    = 5'($urandom_range(0, 3));
      s.urs   = ($urandom_range(0, 1) == 0);
      s.urt   = ($urandom_range(0, 1) == 0);
      s.ulhr  = ($urandom_range(0, 3) == 0);
      s.mrd   = ($urandom_range(0, 2) == 0);
      s.wen   = ($urandom_range(0, 3) != 0);
      s.st    = ($urandom_range(0, 11) == 0);
      s.mul   = ($urandom_range(0, 1) == 0);
      s.redir = ($urandom_range(0, 7) == 0);
      if (i == 1200) async_reset_check();
      else drive(s);
    end
    idle(2);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives PC enable, IF/ID enable/clear, ID/EX clear and EX/MEM clear.
- Detects load-use hazards and flushes on a taken branch/jump resolved in MEM.
- Sequences the multi-cycle mult/div unit (HI/LO): stalls dependent ID instructions until the unit finishes. Also keeps a saturating stall-cycle counter.

Parameters:
- MULT_LAT, 4, cycles a mult occupies the unit (>=1)
- DIV_LAT, 32, cycles a div occupies the unit (>=1)
- CNT_W, 6, latency counter width; must hold max(MULT_LAT,DIV_LAT)-1
- PERF_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs, id_rt  in  5  source register addresses of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_uses_lhr  in  1  ID instruction reads or writes HI/LO, or is mult/div (mfhi/mflo/mthi/mtlo/mult/div)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rf_wen  in  1  instruction in EX writes the register file
- ex_waddr  in  5  destination register of the EX instruction
- ex_md_start  in  1  EX instruction is mult/div (one cycle per instruction)
- ex_md_is_mult  in  1  1 = mult, 0 = div; qualified by ex_md_start
- mem_redirect  in  1  taken branch/jump resolved in MEM
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_clr  out  1  IF/ID synchronous clear
- id_ex_clr  out  1  ID/EX clear (bubble insert)
- ex_mem_clr  out  1  EX/MEM clear
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse; HI/LO written on this edge
- md_overlap_err  out  1  sticky: ex_md_start seen while busy
- stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE, latency counter 0, md_done 0, md_overlap_err 0, stall_cnt 0. Combinational outputs then read pc_en=1, if_id_en=1, all clears 0, md_busy 0.
- FSM states:
  - IDLE: on the edge where ex_md_start=1 and mem_redirect=0, go to RUN and load cnt = (ex_md_is_mult ? MULT_LAT : DIV_LAT) - 1.
  - RUN: if cnt>0, cnt-1. If cnt==0, go to IDLE and set md_done=1 on that edge; md_done clears on the next edge.
- md_busy = (state==RUN), combinational.
- Timing: start sampled at the edge ending cycle T. md_busy is high for cycles T+1..T+LAT. md_done is high in cycle T+LAT+1.
- Hazard terms, combinational, same cycle:
  - lu = ex_mem_read & ex_rf_wen & ex_waddr!=0 & ((id_uses_rs & id_rs==ex_waddr) | (id_uses_rt & id_rt==ex_waddr))
  - mdh = id_uses_lhr & (md_busy | (state==IDLE & ex_md_start))
  - stall = lu | mdh
- Priority:
  1. mem_redirect: pc_en=1, if_id_clr=1, id_ex_clr=1, ex_mem_clr=1, if_id_en=1. Overrides stall; the stalled instruction is wrong-path.
  2. stall: pc_en=0, if_id_en=0, id_ex_clr=1, other clears 0.
  3. Otherwise: pc_en=1, if_id_en=1, all clears 0.
- ex_md_start with mem_redirect in the same cycle: start suppressed (wrong-path), state stays IDLE.
- ex_md_start while RUN: ignored (no reload), md_overlap_err set to 1 until reset.
- stall_cnt increments on every edge where stall=1 and mem_redirect=0; holds at all-ones.
- md_done and a new ex_md_start in the same IDLE cycle are legal: the new operation starts.

Decomposition:
- Shared pipeline package holds:
  - state encoding (IDLE=0, RUN=1)
  - default latency constants
  - register-zero constant
- One natural sub-module: md_seq (FSM, latency counter, md_done, overlap flag).
- Hazard compare, priority mux and stall counter stay in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rf_wen=1, ex_waddr=8, id_rs=8, id_uses_rs=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_clr=1; stall_cnt 0→1. Repeat with ex_waddr=0 -> no stall.
- Mult then mfhi (MULT_LAT=4): ex_md_start=1, ex_md_is_mult=1 at cycle T, id_uses_lhr=1 held -> stall in T..T+4; md_busy high T+1..T+4; md_done pulse at T+5 with pc_en=1; stall_cnt=5.
- Div (DIV_LAT=32) with no LHR users -> md_busy high 32 cycles, zero stalls, md_done single pulse at T+33.
- Redirect during stall: lu=1 and mem_redirect=1 together -> pc_en=1, all three clears 1, stall_cnt unchanged. ex_md_start with mem_redirect -> md_busy stays 0.
- Overlap: second ex_md_start during RUN -> md_overlap_err=1 and stays 1, counter not reloaded, md_done at original time.
- Reset mid-div: assert rst with cnt=10 -> md_busy=0, md_done=0, stall_cnt=0 immediately (asynchronous). After release, pc_en=1.
